// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_adder
// Purpose : carry-segmented pipelined adder/subtractor, one SEG-bit segment per
//           stage. Define ADDER_OVF_FLAG_EN to add the signed-overflow flag ovf.
// Rev     : 1.0  initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH = 81,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH:0]   sum
`ifdef ADDER_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;
  // Operands are zero-padded to whole segments; the carry out of the MSB then
  // lands in bit WIDTH of the padded result whenever padding exists.
  localparam int PW   = NSEG * SEG;

  logic [PW-1:0] a_q [0:NSEG];
  logic [PW-1:0] b_q [0:NSEG-1];
  logic          c_q [0:NSEG];
  logic [NSEG:0] v_q;

  logic [PW-1:0] a_d [1:NSEG];
  logic          c_d [1:NSEG];
  logic [SEG:0]  seg_sum;
  logic [WIDTH-1:0] b_eff;
  logic          cout;

  assign b_eff = sub ? ~b : b;

  // Stage k overwrites segment k-1 of the running a vector with its sum bits.
  always_comb begin
    seg_sum = '0;
    for (int k = 1; k <= NSEG; k++) begin
      a_d[k]  = a_q[k-1];
      seg_sum = {1'b0, a_q[k-1][(k-1)*SEG +: SEG]}
              + {1'b0, b_q[k-1][(k-1)*SEG +: SEG]}
              + (SEG+1)'(c_q[k-1]);
      a_d[k][(k-1)*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[k]  = seg_sum[SEG];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NSEG; k++) begin
        a_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      for (int k = 0; k < NSEG; k++) begin
        b_q[k] <= '0;
      end
      v_q <= '0;
    end else if (ce) begin
      a_q[0] <= PW'(a);
      b_q[0] <= PW'(b_eff);
      c_q[0] <= sub;
      v_q    <= {v_q[NSEG-1:0], in_valid};
      for (int k = 1; k <= NSEG; k++) begin
        a_q[k] <= a_d[k];
        c_q[k] <= c_d[k];
      end
      for (int k = 1; k < NSEG; k++) begin
        b_q[k] <= b_q[k-1];
      end
    end
  end

`ifdef ADDER_OVF_FLAG_EN
  logic cout_d;
`endif

  generate
    if (PW > WIDTH) begin : g_pad
      assign cout = a_q[NSEG][WIDTH];
`ifdef ADDER_OVF_FLAG_EN
      assign cout_d = a_d[NSEG][WIDTH];
`endif
    end else begin : g_nopad
      assign cout = c_q[NSEG];
`ifdef ADDER_OVF_FLAG_EN
      assign cout_d = c_d[NSEG];
`endif
    end
  endgenerate

  assign sum       = {cout, a_q[NSEG][WIDTH-1:0]};
  assign out_valid = v_q[NSEG];

`ifdef ADDER_OVF_FLAG_EN
  logic ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ce) begin
      ovf_q <= a_q[NSEG-1][WIDTH-1] ^ b_q[NSEG-1][WIDTH-1]
             ^ a_d[NSEG][WIDTH-1] ^ cout_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire
